blink_led_arbiter: RTL and testbench

- Shares the board's single status LED between NUM_REQ requesters, each presenting a serial blink pattern.
- Replaces the ripple divider with a synchronous prescaler that produces a one-cycle tick every 2^DIV_WIDTH clocks. For example, DIV_WIDTH=13 on the 10 kHz LFOSC gives about 1.22 Hz.
- A round-robin scheduler grants the LED to one requester for up to HOLD_FRAMES pattern frames, then forces a dark gap of one tick period before the next grant.

---
 rtl/blink_led_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_blink_led_arbiter.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/blink_led_arbiter.sv
// Status-LED arbiter: a synchronous prescaler paces a round-robin scheduler
// that lends the single LED to one requester for up to HOLD_FRAMES pattern
// frames, then forces one dark tick period before the next grant.
// req is level-sensitive: there is no valid/ready handshake. A request is only
// looked at in IDLE, at GAP exit, and by the owner at its own frame end.
module blink_led_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int DIV_WIDTH     = 13,
  parameter int PATTERN_WIDTH = 8,
  parameter int HOLD_FRAMES   = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req,
  input  logic [NUM_REQ*PATTERN_WIDTH-1:0] pattern,
  output logic [NUM_REQ-1:0]               grant,
  output logic                             busy,
  output logic                             tick,
  output logic                             led,
  output logic [1:0]                       dbg_state
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int BIT_W = $clog2(PATTERN_WIDTH);
  localparam int FRM_W = $clog2(HOLD_FRAMES + 1);

  localparam logic [PTR_W-1:0]     LAST_REQ  = PTR_W'(NUM_REQ - 1);
  localparam logic [BIT_W-1:0]     LAST_BIT  = BIT_W'(PATTERN_WIDTH - 1);
  localparam logic [FRM_W-1:0]     LAST_FRM  = FRM_W'(HOLD_FRAMES - 1);
  localparam logic [DIV_WIDTH-1:0] PRESC_MAX = {DIV_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t                   r_state, w_state_next;
  logic [DIV_WIDTH-1:0]     r_presc, w_presc_next;
  logic                     r_tick;
  logic [PTR_W-1:0]         r_rr_ptr, w_rr_next;
  logic [PTR_W-1:0]         r_owner, w_owner_next;
  logic [NUM_REQ-1:0]       r_grant, w_grant_next;
  logic [PATTERN_WIDTH-1:0] r_pat, w_pat_next;
  logic [BIT_W-1:0]         r_bit_idx, w_bit_next;
  logic [FRM_W-1:0]         r_frame_cnt, w_frm_next;
  logic                     r_busy, w_busy_next;
  logic                     r_led, w_led_next;

  logic [PATTERN_WIDTH-1:0] w_pat_arr [NUM_REQ];
  logic                     w_arb_found;
  logic [PTR_W-1:0]         w_arb_idx;
  logic [PTR_W-1:0]         w_arb_next_ptr;
  logic                     w_start;

  // Unpack the flat pattern bus into one slot per requester.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      w_pat_arr[i] = pattern[i*PATTERN_WIDTH +: PATTERN_WIDTH];
    end
  end

  // Round-robin pick: lowest requester at or above rr_ptr, else lowest overall.
  // Both scans run high-to-low so the last hit is the lowest index.
  always_comb begin
    w_arb_found = 1'b0;
    w_arb_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        w_arb_found = 1'b1;
        w_arb_idx   = PTR_W'(i);
      end
    end
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i] && (PTR_W'(i) >= r_rr_ptr)) begin
        w_arb_idx = PTR_W'(i);
      end
    end
    w_arb_next_ptr = (w_arb_idx == LAST_REQ) ? '0 : w_arb_idx + PTR_W'(1);
  end

  // Next-state and next-output logic for the IDLE/PLAY/GAP scheduler.
  always_comb begin
    w_state_next = r_state;
    w_presc_next = (r_presc == PRESC_MAX) ? '0 : r_presc + DIV_WIDTH'(1);
    w_rr_next    = r_rr_ptr;
    w_owner_next = r_owner;
    w_grant_next = r_grant;
    w_pat_next   = r_pat;
    w_bit_next   = r_bit_idx;
    w_frm_next   = r_frame_cnt;
    w_busy_next  = r_busy;
    w_start      = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_arb_found) w_start = 1'b1;
      end
      ST_PLAY: begin
        if (r_tick) begin
          if (r_bit_idx != LAST_BIT) begin
            w_bit_next = r_bit_idx + BIT_W'(1);
          end else if ((r_frame_cnt == LAST_FRM) || !req[r_owner]) begin
            // Owner's turn is over: go dark for one full tick period.
            w_state_next = ST_GAP;
            w_grant_next = '0;
            w_busy_next  = 1'b1;
            w_presc_next = '0;
          end else begin
            // Next frame for the same owner; the pattern is re-sampled here only.
            w_frm_next = r_frame_cnt + FRM_W'(1);
            w_bit_next = '0;
            w_pat_next = w_pat_arr[r_owner];
          end
        end
      end
      ST_GAP: begin
        if (r_tick) begin
          if (w_arb_found) begin
            w_start = 1'b1;
          end else begin
            w_state_next = ST_IDLE;
            w_busy_next  = 1'b0;
          end
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_grant_next = '0;
        w_busy_next  = 1'b0;
      end
    endcase

    // Common grant entry, shared by IDLE and GAP exit.
    if (w_start) begin
      w_state_next = ST_PLAY;
      w_owner_next = w_arb_idx;
      w_grant_next = NUM_REQ'(1) << w_arb_idx;
      w_rr_next    = w_arb_next_ptr;
      w_pat_next   = w_pat_arr[w_arb_idx];
      w_bit_next   = '0;
      w_frm_next   = '0;
      w_busy_next  = 1'b1;
      w_presc_next = '0;
    end

    w_led_next = (w_state_next == ST_PLAY) ? w_pat_next[w_bit_next] : 1'b0;
  end

  // State and output registers; every output comes straight from a flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_presc     <= '0;
      r_tick      <= 1'b0;
      r_rr_ptr    <= '0;
      r_owner     <= '0;
      r_grant     <= '0;
      r_pat       <= '0;
      r_bit_idx   <= '0;
      r_frame_cnt <= '0;
      r_busy      <= 1'b0;
      r_led       <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_presc     <= w_presc_next;
      r_tick      <= (w_presc_next == PRESC_MAX);
      r_rr_ptr    <= w_rr_next;
      r_owner     <= w_owner_next;
      r_grant     <= w_grant_next;
      r_pat       <= w_pat_next;
      r_bit_idx   <= w_bit_next;
      r_frame_cnt <= w_frm_next;
      r_busy      <= w_busy_next;
      r_led       <= w_led_next;
    end
  end

  assign grant     = r_grant;
  assign busy      = r_busy;
  assign tick      = r_tick;
  assign led       = r_led;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_blink_led_arbiter.sv
// Directed bench for blink_led_arbiter with a 4-clock tick period.
// Each expected cycle is the packed word {tick, busy, led, grant[3:0]},
// built from hand-written frame/gap/idle timelines into exp_q.
module tb_blink_led_arbiter;

  localparam int NR = 4;
  localparam int PW = 4;
  localparam int TW = 7;

  logic            clk;
  logic            rst;
  logic [NR-1:0]   req;
  logic [NR*PW-1:0] pattern;
  logic [NR-1:0]   grant;
  logic            busy;
  logic            tick;
  logic            led;
  logic [1:0]      dbg_state;

  logic [TW-1:0] exp_q[$];
  int n_checks;
  int n_fail;
  int cyc;

  blink_led_arbiter #(
    .NUM_REQ(4), .DIV_WIDTH(2), .PATTERN_WIDTH(4), .HOLD_FRAMES(2)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .pattern(pattern),
    .grant(grant), .busy(busy), .tick(tick), .led(led), .dbg_state(dbg_state)
  );

  // Clock and reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  // Timeline builders
  task automatic push_frame(input logic [NR-1:0] g, input logic [PW-1:0] pat);
    for (int k = 0; k < 16; k++) exp_q.push_back({(k % 4) == 3, 1'b1, pat[k/4], g});
  endtask

  task automatic push_gap();
    for (int k = 0; k < 4; k++) exp_q.push_back({k == 3, 1'b1, 1'b0, 4'b0000});
  endtask

  task automatic push_idle(input int n, input int phase);
    for (int k = 0; k < n; k++) exp_q.push_back({(k % 4) == phase, 1'b0, 1'b0, 4'b0000});
  endtask

  // Scoreboard: compare n cycles against the head of exp_q, sampling at negedge
  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cyc++;
      if (exp_q.size() == 0) begin
        check($sformatf("trace_empty@%0d", cyc), {tick, busy, led, grant}, 7'h7f);
      end else begin
        check($sformatf("trace@%0d", cyc), {tick, busy, led, grant}, exp_q.pop_front());
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_grant"}, {3'b000, grant}, 7'd0);
    check({tag, "_led"},   {6'd0, led},     7'd0);
    check({tag, "_busy"},  {6'd0, busy},    7'd0);
    check({tag, "_tick"},  {6'd0, tick},    7'd0);
    check({tag, "_state"}, {5'd0, dbg_state}, 7'd0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    rst      = 1'b0;
    req      = '0;
    pattern  = '0;

    // Reset state, then idle prescaler ticking every 4th clock
    #1;
    check_reset_outputs("por");
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("reset_held");
    rst = 1'b1;
    push_idle(12, 2);
    run_cycles(12);

    // Single owner with two frames, gap, regrant, then early release
    pattern[3:0] = 4'b0110;
    req = 4'b0001;
    push_frame(4'b0001, 4'b0110);
    push_frame(4'b0001, 4'b0110);
    push_gap();
    push_frame(4'b0001, 4'b0110);
    push_gap();
    push_idle(8, 3);
    run_cycles(40);
    req = 4'b0000;
    run_cycles(24);

    // Pattern change mid-frame is held off until the frame boundary;
    // all requests dropping during the gap returns to IDLE
    req = 4'b0001;
    push_frame(4'b0001, 4'b0110);
    push_frame(4'b0001, 4'b1111);
    push_gap();
    push_idle(4, 3);
    run_cycles(6);
    pattern[3:0] = 4'b1111;
    run_cycles(28);
    req = 4'b0000;
    run_cycles(6);

    // Round-robin between requesters 0 and 2 (pointer currently at 1)
    pattern[3:0]  = 4'b0110;
    pattern[11:8] = 4'b1001;
    req = 4'b0101;
    push_frame(4'b0100, 4'b1001);
    push_frame(4'b0100, 4'b1001);
    push_gap();
    push_frame(4'b0001, 4'b0110);
    push_frame(4'b0001, 4'b0110);
    push_gap();
    push_frame(4'b0100, 4'b1001);
    run_cycles(76);

    // Asynchronous reset mid-PLAY with owner 2, right after a tick
    rst = 1'b0;
    #1;
    check_reset_outputs("rst_owner2");
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    push_frame(4'b0001, 4'b0110);
    run_cycles(6);

    // Reset again with owner 0: pointer must return to 0, so requester 0 wins again
    rst = 1'b0;
    #1;
    check_reset_outputs("rst_owner0");
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    push_frame(4'b0001, 4'b0110);
    run_cycles(16);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
